// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Converts one decoded load or store into a single word-aligned req/ack bus
// transaction. The core is stalled while the transaction is outstanding. Load
// results come back sign- or zero-extended.
//
// FSM: IDLE -> REQ -> RESP -> IDLE. A zero-wait ack gives 3 cycles per access.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of REQ cycles spent waiting for bus_ack
//                    before the access is aborted with bus_err. 0 disables
//                    the timeout.
//
// Configuration macro
//   MISALIGN_TRAP_EN : when defined, halfword accesses with addr[0]=1 and word
//                      accesses with addr[1:0]!=0 skip the bus entirely and
//                      report a misaligned pulse. When undefined, misaligned
//                      is tied low, halfwords use addr[1] only, and words
//                      ignore addr[1:0].
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_read_control    load request from the decoder
//   mem_write_control   store request from the decoder (wins over read)
//   funct3              000 B, 001 H, 010 W, 100 BU, 101 HU (others: word)
//   addr                byte address from the ALU
//   store_data          rs2 value for stores
//   stall               core must hold the current instruction
//   load_data           extended load result, qualified by load_valid
//   load_valid          1-cycle pulse in RESP for loads
//   bus_err             1-cycle pulse in RESP after a bus timeout
//   misaligned          1-cycle pulse in RESP for a trapped misaligned access
//   bus_req             request, held until bus_ack
//   bus_we              1 = write
//   bus_addr            word-aligned address
//   bus_wdata           store data replicated across lanes
//   bus_wstrb           byte enables (0 for reads)
//   bus_ack             transaction done, bus_rdata valid in the same cycle
//   bus_rdata           read word
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_control,
  input  logic        mem_write_control,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value on the last REQ cycle allowed before the abort.
  localparam logic [31:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] tmo_cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        req_in;
  logic        is_byte_in;
  logic        is_half_in;
  logic        mis_in;
  logic        timeout_hit;

  // funct3[1:0] selects size; 011/110/111 fall through to word.
  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    if (f3[1:0] == 2'b00)      s = 4'b0001 << off;
    else if (f3[1:0] == 2'b01) s = off[1] ? 4'b1100 : 4'b0011;
    else                       s = 4'b1111;
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    if (f3[1:0] == 2'b00)      w = {4{d[7:0]}};
    else if (f3[1:0] == 2'b01) w = {2{d[15:0]}};
    else                       w = d;
    return w;
  endfunction

  // Lane extraction followed by sign extension (funct3[2]=0) or zero extension.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0]        byte_sh;
    logic [31:0]        half_sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        r;
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    b_s     = byte_sh[7:0];
    h_s     = half_sh[15:0];
    if (f3[1:0] == 2'b00)      r = f3[2] ? {24'd0, byte_sh[7:0]} : 32'(b_s);
    else if (f3[1:0] == 2'b01) r = f3[2] ? {16'd0, half_sh[15:0]} : 32'(h_s);
    else                       r = word;
    return r;
  endfunction

  assign req_in     = mem_read_control | mem_write_control;
  assign is_byte_in = (funct3[1:0] == 2'b00);
  assign is_half_in = (funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign mis_in = (is_half_in & addr[0]) |
                  (~is_byte_in & ~is_half_in & (addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  // Stall is combinational in IDLE so the accepting cycle is already held;
  // gating with rst_n makes it drop the moment reset is asserted.
  assign stall = rst_n & ((state == REQ) | ((state == IDLE) & req_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= 32'd0;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_wstrb  <= 4'd0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        // ---- accept stage: capture the access and drive the bus ----
        IDLE: begin
          if (req_in) begin
            we_q     <= mem_write_control;
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            tmo_cnt  <= 32'd0;
            if (mis_in) begin
              state      <= RESP;
              misaligned <= 1'b1;
              load_data  <= 32'd0;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= mem_write_control;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= mem_write_control ? lane_strb(funct3, addr[1:0]) : 4'd0;
              bus_wdata <= mem_write_control ? lane_wdata(funct3, store_data) : 32'd0;
            end
          end
        end
        // ---- bus stage: wait for ack; ack beats a simultaneous timeout ----
        REQ: begin
          if (bus_ack) begin
            state   <= RESP;
            bus_req <= 1'b0;
            if (!we_q) begin
              load_valid <= 1'b1;
              load_data  <= extend_load(funct3_q, off_q, bus_rdata);
            end
          end else if (timeout_hit) begin
            state      <= RESP;
            bus_req    <= 1'b0;
            bus_err    <= 1'b1;
            load_data  <= 32'd0;
            load_valid <= ~we_q;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        // ---- response stage: core advances; controls seen here are ignored ----
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
